// File: rtl/varredura_matriz_pkg.sv
// Shared constants and helpers for the LED matrix / display scan controller.
// Scan code 0 selects digit D1; codes 1..7 select rows L1..L7.
package scan_pkg;

    localparam int SCAN_W = 3;
    localparam int NUM_SW = 5;
    localparam logic [SCAN_W-1:0] ROW_DISPLAY = 3'd0;
    localparam logic [SCAN_W-1:0] ROW_LAST    = 3'd7;

    typedef logic [SCAN_W-1:0] scan_code_t;
    typedef logic [NUM_SW-1:0] char_code_t;

    // Bits needed to hold 0..value-1; never less than one so DIV=1 still gets a counter.
    function automatic int clog2(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/varredura_matriz_if.sv
// Switch inputs and scan/character outputs of the scan controller.
// master is the controller side, slave is the consumer (decoders or bench).
interface varredura_matriz_if;
    import scan_pkg::*;

    char_code_t sw_in;
    logic A1, B1, C1;
    logic A, B, C, D, E;
    logic tick;
    logic frame_start;

    modport master (
        input  sw_in,
        output A1, B1, C1, A, B, C, D, E, tick, frame_start
    );

    modport slave (
        output sw_in,
        input  A1, B1, C1, A, B, C, D, E, tick, frame_start
    );

endinterface

// File: rtl/varredura_matriz_debounce_bit.sv
// Tick-based debouncer for one synchronized switch bit: the stable value only
// follows the input after DEB_TICKS consecutive differing scan ticks.
module debounce_bit
    import scan_pkg::*;
#(
    parameter int DEB_TICKS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic sync_i,
    output logic stable_o
);

    localparam int CW = clog2(DEB_TICKS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (tick_i) begin
            if (sync_i == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(DEB_TICKS - 1)) begin
                stable_d = sync_i;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/varredura_matriz.sv
// Scan controller: prescaler, 8-step row/digit scan counter, switch sync and
// debounce, and a character latch that only updates at frame boundaries.
module varredura_matriz
    import scan_pkg::*;
#(
    parameter int DIV       = 50000,
    parameter int DEB_TICKS = 8
) (
    input  logic clk,
    input  logic rst,
    varredura_matriz_if.master bus
);

    localparam int CNT_W = clog2(DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_d, tick_q;
    scan_code_t       row_q, row_d;
    char_code_t       sync1_q, sync2_q;
    char_code_t       stable_w;
    char_code_t       char_q, char_d;
    logic             frame_start_d, frame_start_q;

    // tick_d is the internal step strobe; tick_q is its registered copy, so the
    // scan code and the tick output change on the same edge.
    always_comb begin
        tick_d        = (cnt_q == CNT_W'(DIV - 1));
        cnt_d         = tick_d ? '0 : cnt_q + 1'b1;
        row_d         = row_q;
        frame_start_d = 1'b0;
        char_d        = char_q;
        if (tick_d) begin
            row_d = (row_q == ROW_LAST) ? ROW_DISPLAY : row_q + 1'b1;
            if (row_q == ROW_LAST) begin
                frame_start_d = 1'b1;
                // stable_w is still the pre-update value on this edge
                char_d        = stable_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            tick_q        <= 1'b0;
            row_q         <= ROW_DISPLAY;
            sync1_q       <= '0;
            sync2_q       <= '0;
            char_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            tick_q        <= tick_d;
            row_q         <= row_d;
            sync1_q       <= bus.sw_in;
            sync2_q       <= sync1_q;
            char_q        <= char_d;
            frame_start_q <= frame_start_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_deb
            debounce_bit #(
                .DEB_TICKS (DEB_TICKS)
            ) u_deb (
                .clk      (clk),
                .rst      (rst),
                .tick_i   (tick_d),
                .sync_i   (sync2_q[gi]),
                .stable_o (stable_w[gi])
            );
        end
    endgenerate

    assign {bus.A1, bus.B1, bus.C1}           = row_q;
    assign {bus.A, bus.B, bus.C, bus.D, bus.E} = char_q;
    assign bus.tick                            = tick_q;
    assign bus.frame_start                     = frame_start_q;

endmodule

// File: tb/tb_varredura_matriz.sv
// Self-checking bench: two instances (DIV=4/DEB_TICKS=3 and DIV=1/DEB_TICKS=1),
// cycle-index reference for scan timing, and a queue of frame-latch expectations.
module tb_varredura_matriz;
    import scan_pkg::*;

    logic clk = 1'b0;
    logic rst0, rst1;
    always #5 clk = ~clk;

    varredura_matriz_if if0();
    varredura_matriz_if if1();

    varredura_matriz #(.DIV(4), .DEB_TICKS(3)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
    varredura_matriz #(.DIV(1), .DEB_TICKS(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1));

    typedef struct {
        int         delay;
        logic [4:0] sw;
        int         pulse;
        logic [4:0] exp;
    } vec_t;

    vec_t       vecs0[9];
    vec_t       vecs1[4];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [4:0] q0[$];
    logic [4:0] q1[$];
    logic [4:0] exp0 = '0;
    logic [4:0] exp1 = '0;
    logic [4:0] steady0, steady1;
    int         k0 = 0;
    int         k1 = 0;
    bit         en0 = 1'b0;
    bit         en1 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, req);
        end
    endtask

    // Edges since the last reset edge; every timing expectation derives from it.
    always @(posedge clk) begin
        k0  <= rst0 ? 0 : k0 + 1;
        en0 <= en0 | rst0;
        k1  <= rst1 ? 0 : k1 + 1;
        en1 <= en1 | rst1;
    end

    always @(negedge clk) begin
        if (en0) begin
            check("d0_tick", 32'(if0.tick), 32'(k0 > 0 && k0 % 4 == 0));
            check("d0_code", 32'({if0.A1, if0.B1, if0.C1}), 32'((k0 / 4) % 8));
            check("d0_fstart", 32'(if0.frame_start), 32'(k0 > 0 && k0 % 32 == 0));
            if (k0 == 0) begin
                exp0 = '0;
            end else if (k0 % 32 == 0 && q0.size() > 0) begin
                exp0 = q0.pop_front();
                $display("dut0 frame k=%0d abcde=%b expect=%b", k0,
                         {if0.A, if0.B, if0.C, if0.D, if0.E}, exp0);
            end
            check("d0_abcde", 32'({if0.A, if0.B, if0.C, if0.D, if0.E}), 32'(exp0));
        end
    end

    always @(negedge clk) begin
        if (en1) begin
            check("d1_tick", 32'(if1.tick), 32'(k1 > 0));
            check("d1_code", 32'({if1.A1, if1.B1, if1.C1}), 32'(k1 % 8));
            check("d1_fstart", 32'(if1.frame_start), 32'(k1 > 0 && k1 % 8 == 0));
            if (k1 == 0) begin
                exp1 = '0;
            end else if (k1 % 8 == 0 && q1.size() > 0) begin
                exp1 = q1.pop_front();
                $display("dut1 frame k=%0d abcde=%b expect=%b", k1,
                         {if1.A, if1.B, if1.C, if1.D, if1.E}, exp1);
            end
            check("d1_abcde", 32'({if1.A, if1.B, if1.C, if1.D, if1.E}), 32'(exp1));
        end
    end

    // Called on a frame-start negedge; returns on the next one.
    task automatic run_vec(input bit sel, input vec_t v, input int flen);
        int t;
        t = 0;
        repeat (v.delay) begin @(negedge clk); t++; end
        $display("drive dut%0d sw=%b delay=%0d pulse=%0d expect=%b", sel, v.sw, v.delay, v.pulse, v.exp);
        if (sel) begin
            if1.sw_in = v.sw;
            q1.push_back(v.exp);
        end else begin
            if0.sw_in = v.sw;
            q0.push_back(v.exp);
        end
        if (v.pulse > 0) begin
            repeat (v.pulse) begin @(negedge clk); t++; end
            if (sel) if1.sw_in = steady1;
            else     if0.sw_in = steady0;
        end else begin
            if (sel) steady1 = v.sw;
            else     steady0 = v.sw;
        end
        while (t < flen) begin @(negedge clk); t++; end
    endtask

    initial begin
        vecs0[0] = '{0,  5'b00000, 0, 5'b00000};
        vecs0[1] = '{0,  5'b00001, 8, 5'b00000};
        vecs0[2] = '{0,  5'b00001, 4, 5'b00000};
        vecs0[3] = '{0,  5'b00000, 0, 5'b00000};
        vecs0[4] = '{0,  5'b10110, 0, 5'b10110};
        vecs0[5] = '{20, 5'b01001, 0, 5'b10110};
        vecs0[6] = '{0,  5'b01001, 0, 5'b01001};
        vecs0[7] = '{5,  5'b11100, 0, 5'b11100};
        vecs0[8] = '{0,  5'b10110, 0, 5'b10110};

        vecs1[0] = '{0, 5'b10101, 0, 5'b10101};
        vecs1[1] = '{4, 5'b01010, 0, 5'b01010};
        vecs1[2] = '{5, 5'b11111, 0, 5'b01010};
        vecs1[3] = '{0, 5'b11111, 0, 5'b11111};

        rst0 = 1'b1;
        rst1 = 1'b1;
        if0.sw_in = 5'b11111;
        if1.sw_in = 5'b00000;
        steady0 = 5'b11111;
        steady1 = 5'b00000;
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        q0.push_back(5'b11111);
        repeat (32) @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(1'b0, vecs0[i], 32);

        // Reset in the middle of a frame while row 5 is being scanned.
        repeat (20) @(negedge clk);
        check("midrst_pre_code", 32'({if0.A1, if0.B1, if0.C1}), 32'd5);
        check("midrst_pre_abcde", 32'({if0.A, if0.B, if0.C, if0.D, if0.E}), 32'b10110);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        check("midrst_code", 32'({if0.A1, if0.B1, if0.C1}), 32'd0);
        check("midrst_abcde", 32'({if0.A, if0.B, if0.C, if0.D, if0.E}), 32'd0);
        check("midrst_tick", 32'(if0.tick), 32'd0);
        q0.delete();
        q0.push_back(5'b10110);
        repeat (32) @(negedge clk);

        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        q1.delete();
        for (int i = 0; i < 4; i++) run_vec(1'b1, vecs1[i], 8);

        @(negedge clk);
        check("sb0_drain", 32'(q0.size()), 32'd0);
        check("sb1_drain", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/varredura_matriz.md
Name: varredura_matriz

Overview:
- Upstream scan controller for the 7x5 LED matrix / 4-digit display output stage.
- Generates the 3-bit row/digit scan code `{A1,B1,C1}`:
  - code 0 enables digit D1;
  - codes 1..7 enable rows L1..L7.
- Conditions the five raw character switches (sync + debounce).
- Presents the resulting character code `A..E` only at frame boundaries, so a frame is never drawn with mixed codes.

Parameters:
- DIV, 50000, prescaler terminal count; one scan step every DIV clk cycles (1 kHz step at 50 MHz); DIV >= 1.
- DEB_TICKS, 8, number of consecutive scan ticks a switch must differ from its stable value before the stable value updates; DEB_TICKS >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- sw_in  in  5  raw asynchronous switches; sw_in[4] maps to A … sw_in[0] maps to E.
- A1  out  1  scan code MSB.
- B1  out  1  scan code middle bit.
- C1  out  1  scan code LSB.
- A, B, C, D, E  out  1 each  debounced, frame-latched character code for the matrix/display decoders.
- tick  out  1  one-cycle pulse on every scan step.
- frame_start  out  1  one-cycle pulse on the cycle the scan code becomes 000.

Behaviour:
- One clock; reset is synchronous and active-high.
  - rst sampled high at a clk edge clears all state.
  - After that edge: prescaler=0, scan code=000, sync flops=0, stable values=0, debounce counters=0, A..E=0, tick=0, frame_start=0.
  - rst overrides every other event, including mid-frame.
- Prescaler:
  - cnt counts 0..DIV-1 and wraps.
  - tick is registered: high for the one cycle after cnt==DIV-1.
  - After reset release, the first tick is high on the DIV-th rising edge.
  - With DIV=1, tick is high every cycle after reset.
- Scan counter r[2:0]:
  - Increments by 1 on the edge where tick is internally asserted; 7 wraps to 0. No other wrap point.
  - `{A1,B1,C1}` = r, driven directly from the register, so codes change on the same cycle tick is high.
  - The full frame is 8 steps: digit D1, then rows 1..7.
- Synchronizer: two flops per bit on sw_in, giving sync[4:0]; latency 2 cycles.
- Debounce, per bit, evaluated only on tick:
  - if sync == stable: counter cleared;
  - else if counter == DEB_TICKS-1: stable <= sync and counter cleared;
  - else: counter + 1.
  - Any return to the stable value before reaching DEB_TICKS clears the count; glitches are rejected.
- Frame latch:
  - On the tick where r goes 7→0, `{A,B,C,D,E}` <= stable.
  - frame_start is high on the same cycle the scan code reads 000.
  - If stable changes on that same tick, the latch takes the pre-update stable value; the new value appears one frame later.
- Between frame latches, A..E are constant regardless of switch activity.

Decomposition:
- Shared package (`scan_pkg`):
  - constants SCAN_W=3, ROW_DISPLAY=3'd0, ROW_LAST=3'd7, NUM_SW=5;
  - function clog2 for prescaler/debounce counter widths.
- One natural sub-module, `debounce_bit`:
  - inputs: clk, rst, tick, sync bit;
  - output: stable bit;
  - parameter: DEB_TICKS;
  - instantiated NUM_SW times.
- Prescaler, scan counter, synchronizer and frame latch stay in the top.

Test Plan (DIV=4, DEB_TICKS=3 unless stated):
- Reset: rst high 3 cycles, sw_in=5'b11111 → all outputs 0 during and after reset. First tick on the 4th edge after release; scan code 001 on that cycle.
- Scan sequence: run 40 cycles → scan code steps 000,001,…,111,000 once every 4 cycles. frame_start pulses exactly when 000 reappears (cycle 32), never elsewhere.
- Glitch rejection: sw_in[0] high for 2 ticks then low → E stays 0 through 3 full frames; internal stable[0] never changes.
- Clean change: sw_in=5'b10110 held → stable updates 3 ticks after sync. A,B,C,D,E = 1,0,1,1,0 appears only at the next frame_start; values unchanged at every earlier row step.
- Reset mid-frame: assert rst while scan code=101 and A..E=10110 → next edge gives scan code 000, A..E=00000, tick=0. Prescaler restarts and the first tick comes 4 cycles after release.
- DIV=1, DEB_TICKS=1: tick high every cycle; scan code increments each cycle. A held switch change reaches A..E at the first frame_start after stable updates (at most 8 cycles + 2 sync cycles).
